game_counter_gen2: RTL and testbench
====================================

# game_counter_gen2

Parametrised second-generation game counter for the counter verification environment. Holds a COUNTER_SIZE-bit score that steps by ±1/±2 per cycle, pulses LOSER at zero and WINNER at all-ones, and tallies each outcome. When either tally reaches a configurable limit it enters a sticky game-over state that reports the result on WHO. Compared with the first-generation counter it adds an explicit state machine, a count-enable input, a visible count, configurable tally width and limit, and optional saturating arithmetic.

## Interface
- COUNTER_SIZE, 4, score width in bits; must be ≥ 2.
- TALLY_SIZE, 4, width of the internal win and lose tallies.
- TALLY_LIMIT, 15, tally value that ends the game; must satisfy 1 ≤ TALLY_LIMIT < 2^TALLY_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- INIT  in  1  load/restart strobe.
- loadValue  in  COUNTER_SIZE  score loaded on INIT.
- ctrl  in  2  step mode: 00 = +1, 01 = +2, 10 = −1, 11 = −2.
- en  in  1  count enable.
- count  out  COUNTER_SIZE  current score register.
- LOSER  out  1  one-cycle pulse, score reached 0.
- WINNER  out  1  one-cycle pulse, score reached MAX = 2^COUNTER_SIZE − 1.
- GAMEOVER  out  1  sticky game-over flag.
- WHO  out  2  result: 00 = none, 01 = loser tally won, 10 = winner tally won.

## Operation
- States: IDLE, RUN, OVER.
- Reset values: state IDLE; count 0; tallies 0; LOSER, WINNER, GAMEOVER 0; WHO 00.
- Priority, evaluated at every rising clk edge: INIT, then state behaviour.
- INIT = 1, in any state:
  - count ← loadValue; tallies ← 0; LOSER, WINNER, GAMEOVER ← 0; WHO ← 00; state → RUN.
  - No flag fires on the load itself, even when loadValue is 0 or MAX.
- IDLE: ctrl and en are ignored; outputs hold their reset values.
- RUN with en = 0: count and tallies hold; LOSER and WINNER are forced to 0.
- RUN with en = 1:
  - count_next = count ± step per ctrl.
  - Arithmetic is modulo 2^COUNTER_SIZE (wraps), unless the Configuration macro is defined.
  - count ← count_next.
  - LOSER ← (count_next == 0).
  - WINNER ← (count_next == MAX).
  - Each flag that asserts increments its tally at the same edge.
  - If the incremented tally equals TALLY_LIMIT:
    - GAMEOVER ← 1 and state → OVER at that same edge.
    - WHO ← 01 for the lose tally, 10 for the win tally.
    - The final LOSER/WINNER pulse is still emitted.
- OVER:
  - count, tallies, GAMEOVER and WHO are frozen.
  - LOSER and WINNER return to 0 on the next edge.
  - Only INIT or reset leaves OVER.
- Simultaneous LOSER and WINNER cannot occur, because COUNTER_SIZE ≥ 2.
- Tallies never exceed TALLY_LIMIT.

## Timing
- All outputs are registered.
- Step-to-output latency is 1 cycle: count, LOSER and WINNER reflect the step sampled at edge N, visible after edge N.
- LOSER and WINNER are high for exactly one cycle per qualifying step. Back-to-back qualifying steps give consecutive high cycles.
- GAMEOVER rises in the same cycle as the terminal LOSER/WINNER pulse.
- Reset is asynchronous: rst_l low clears everything immediately, mid-operation or in OVER.
- Reset release is synchronous to clk; the first INIT is honoured on the first edge after release.
- An INIT held for several cycles reloads loadValue on each edge; counting resumes on the first edge after INIT deasserts.

## Configuration
- GAME_CNT_SAT_EN defined:
  - Saturating arithmetic: up-steps clamp at MAX, down-steps clamp at 0.
  - Example: 14 + 2 → 15.
  - While clamped, WINNER (at MAX) or LOSER (at 0) re-asserts and the tally increments every enabled cycle.
- GAME_CNT_SAT_EN undefined:
  - Modulo wrap.
  - Examples: 15 + 1 → 0 (LOSER); 14 + 2 → 0 (LOSER, no WINNER); 1 − 2 → 15 (WINNER).

## Test plan
- Reset: run with count = 7, drop rst_l between edges → all outputs 0 immediately; after release, ctrl = 00 with en = 1 leaves count at 0 until INIT.
- Wrap (macro off, defaults): INIT loadValue = 13, then ctrl = 01, en = 1 → count 15 with WINNER = 1 for one cycle, then count 1 with WINNER = 0.
- Saturate (macro on): INIT loadValue = 14, ctrl = 01 for 3 cycles → count 15, 15, 15; WINNER high all 3 cycles; win tally 3.
- Game over: TALLY_LIMIT = 2, INIT loadValue = 1; ctrl 10, 00, 10 with en = 1 → count 0, 1, 0; LOSER on the 1st and 3rd cycles; GAMEOVER = 1 and WHO = 01 on the 3rd cycle.
  - Further steps leave count = 0, LOSER = 0, GAMEOVER = 1.
- Enable and restart: in RUN, hold en = 0 for 4 cycles → count unchanged, no pulses. Then, in OVER, INIT loadValue = 5 → GAMEOVER = 0, WHO = 00, count 5, state RUN.

Source files
------------

// File: rtl/game_counter_gen2.sv
// game_counter_gen2: second-generation game counter.
// Holds a COUNTER_SIZE-bit score stepped by +1/+2/-1/-2 while enabled, pulses
// LOSER at zero and WINNER at all-ones, tallies each outcome and latches a
// sticky game-over result once either tally reaches TALLY_LIMIT.
// Optional feature macro: GAME_CNT_SAT_EN selects saturating arithmetic
// (clamp at 0 and MAX); without it the score wraps modulo 2^COUNTER_SIZE.
module game_counter_gen2 #(
    parameter int COUNTER_SIZE = 4,
    parameter int TALLY_SIZE   = 4,
    parameter int TALLY_LIMIT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    INIT,
    input  logic [COUNTER_SIZE-1:0] loadValue,
    input  logic [1:0]              ctrl,
    input  logic                    en,
    output logic [COUNTER_SIZE-1:0] count,
    output logic                    LOSER,
    output logic                    WINNER,
    output logic                    GAMEOVER,
    output logic [1:0]              WHO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [COUNTER_SIZE-1:0] MAX     = '1;
    localparam logic [TALLY_SIZE-1:0]   LIMIT_T = TALLY_SIZE'(TALLY_LIMIT);

    state_t                  state;
    logic [TALLY_SIZE-1:0]   win_tally;
    logic [TALLY_SIZE-1:0]   lose_tally;
    logic [TALLY_SIZE-1:0]   win_inc;
    logic [TALLY_SIZE-1:0]   lose_inc;
    logic [COUNTER_SIZE-1:0] step;
    logic [COUNTER_SIZE-1:0] count_next;
    logic                    hit_zero;
    logic                    hit_max;
`ifdef GAME_CNT_SAT_EN
    logic [COUNTER_SIZE:0]   up_sum;
`endif

    // Next score for the selected step, plus the flag and tally lookahead values
    always_comb begin
        step = ctrl[0] ? COUNTER_SIZE'(2) : COUNTER_SIZE'(1);
`ifdef GAME_CNT_SAT_EN
        up_sum = {1'b0, count} + {1'b0, step};
        if (!ctrl[1]) begin
            count_next = up_sum[COUNTER_SIZE] ? MAX : up_sum[COUNTER_SIZE-1:0];
        end else begin
            count_next = (count < step) ? '0 : (count - step);
        end
`else
        count_next = ctrl[1] ? (count - step) : (count + step);
`endif
        hit_zero = (count_next == '0);
        hit_max  = (count_next == MAX);
        win_inc  = win_tally + TALLY_SIZE'(1);
        lose_inc = lose_tally + TALLY_SIZE'(1);
    end

    // Game state machine with all outputs registered; INIT overrides any state
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            count      <= '0;
            win_tally  <= '0;
            lose_tally <= '0;
            LOSER      <= 1'b0;
            WINNER     <= 1'b0;
            GAMEOVER   <= 1'b0;
            WHO        <= 2'b00;
        end else if (INIT) begin
            state      <= RUN;
            count      <= loadValue;
            win_tally  <= '0;
            lose_tally <= '0;
            LOSER      <= 1'b0;
            WINNER     <= 1'b0;
            GAMEOVER   <= 1'b0;
            WHO        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    LOSER  <= 1'b0;
                    WINNER <= 1'b0;
                    if (en) begin
                        count <= count_next;
                        if (hit_zero) begin
                            LOSER      <= 1'b1;
                            lose_tally <= lose_inc;
                            if (lose_inc == LIMIT_T) begin
                                GAMEOVER <= 1'b1;
                                WHO      <= 2'b01;
                                state    <= OVER;
                            end
                        end
                        if (hit_max) begin
                            WINNER    <= 1'b1;
                            win_tally <= win_inc;
                            if (win_inc == LIMIT_T) begin
                                GAMEOVER <= 1'b1;
                                WHO      <= 2'b10;
                                state    <= OVER;
                            end
                        end
                    end
                end
                OVER: begin
                    LOSER  <= 1'b0;
                    WINNER <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_counter_gen2.sv
// tb_game_counter_gen2: scoreboard bench for game_counter_gen2.
// Two instances share the stimulus: dut_a with default parameters and dut_b
// with TALLY_LIMIT = 2 so game-over is reached quickly. A behavioural model
// predicts both instances; predictions are queued when stimulus is driven and
// compared one cycle later when the registered outputs appear.
module tb_game_counter_gen2;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] cnt;
        logic [3:0] wt;
        logic [3:0] lt;
        logic       lo;
        logic       wi;
        logic       go;
        logic [1:0] who;
    } model_t;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_OVER = 2'd2;

    logic       clk;
    logic       rst_l;
    logic       init;
    logic [3:0] load_value;
    logic [1:0] ctrl;
    logic       en;

    logic [3:0] count_a, count_b;
    logic       loser_a, loser_b;
    logic       winner_a, winner_b;
    logic       gameover_a, gameover_b;
    logic [1:0] who_a, who_b;
    logic [17:0] obs_now;

    model_t       ma, mb;
    logic [17:0]  sb[$];
    logic [17:0]  exp_v;
    int           total;
    int           bad;

    game_counter_gen2 dut_a (
        .clk(clk), .rst_l(rst_l), .INIT(init), .loadValue(load_value),
        .ctrl(ctrl), .en(en), .count(count_a), .LOSER(loser_a),
        .WINNER(winner_a), .GAMEOVER(gameover_a), .WHO(who_a)
    );

    game_counter_gen2 #(.COUNTER_SIZE(4), .TALLY_SIZE(4), .TALLY_LIMIT(2)) dut_b (
        .clk(clk), .rst_l(rst_l), .INIT(init), .loadValue(load_value),
        .ctrl(ctrl), .en(en), .count(count_b), .LOSER(loser_b),
        .WINNER(winner_b), .GAMEOVER(gameover_b), .WHO(who_b)
    );

    assign obs_now = {count_a, loser_a, winner_a, gameover_a, who_a,
                      count_b, loser_b, winner_b, gameover_b, who_b};

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observable outputs of one model instance: count, LOSER, WINNER, GAMEOVER, WHO
    function automatic logic [8:0] outs(input model_t m);
        return {m.cnt, m.lo, m.wi, m.go, m.who};
    endfunction

    // One clock edge of the reference behaviour for a given tally limit
    function automatic model_t model_step(input model_t m, input int limit,
                                          input logic i, input logic [3:0] lv,
                                          input logic [1:0] c, input logic e);
        model_t n;
        int     v;
        n = m;
        if (i) begin
            n     = '0;
            n.st  = M_RUN;
            n.cnt = lv;
            return n;
        end
        if (m.st == M_RUN) begin
            n.lo = 1'b0;
            n.wi = 1'b0;
            if (e) begin
                case (c)
                    2'b00:   v = int'(m.cnt) + 1;
                    2'b01:   v = int'(m.cnt) + 2;
                    2'b10:   v = int'(m.cnt) - 1;
                    default: v = int'(m.cnt) - 2;
                endcase
`ifdef GAME_CNT_SAT_EN
                if (v > 15) v = 15;
                if (v < 0) v = 0;
`else
                v = v & 15;
`endif
                n.cnt = v[3:0];
                if (v == 0) begin
                    n.lo = 1'b1;
                    n.lt = m.lt + 4'd1;
                    if (int'(n.lt) == limit) begin
                        n.go = 1'b1; n.who = 2'b01; n.st = M_OVER;
                    end
                end
                if (v == 15) begin
                    n.wi = 1'b1;
                    n.wt = m.wt + 4'd1;
                    if (int'(n.wt) == limit) begin
                        n.go = 1'b1; n.who = 2'b10; n.st = M_OVER;
                    end
                end
            end
        end else if (m.st == M_OVER) begin
            n.lo = 1'b0;
            n.wi = 1'b0;
        end
        return n;
    endfunction

    // Drive one cycle of inputs and queue the predicted post-edge outputs
    task automatic applyStimulus(input logic i, input logic [3:0] lv,
                                 input logic [1:0] c, input logic e);
        init       = i;
        load_value = lv;
        ctrl       = c;
        en         = e;
        ma = model_step(ma, 15, i, lv, c, e);
        mb = model_step(mb, 2, i, lv, c, e);
        sb.push_back({outs(ma), outs(mb)});
    endtask

    // Reset values, IDLE ignoring steps, and asynchronous reset mid-run
    task automatic test_reset();
        rst_l = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs_now !== 18'h0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want %h", obs_now, 18'h0);
        end
        rst_l = 1'b1;
        ma = '0; mb = '0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0, 1:    applyStimulus(1'b0, 4'd9, 2'b00, 1'b1);
                2:       applyStimulus(1'b1, 4'd6, 2'b00, 1'b1);
                default: applyStimulus(1'b0, 4'd0, 2'b00, 1'b1);
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL reset_idle step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
        #2 rst_l = 1'b0;
        #1;
        total++;
        if (obs_now !== 18'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: got %h want %h", obs_now, 18'h0);
        end
        ma = '0; mb = '0;
        @(posedge clk); #1;
        rst_l = 1'b1;
    endtask

    // Modulo wrap at the top and bottom of the score range
    task automatic test_wrap();
        logic [1:0] steps [5] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k == 0, 4'd13, steps[k], 1'b1);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL wrap step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
    endtask

    // Lose tally reaching the limit on dut_b, then frozen OVER state
    task automatic test_game_over();
        logic [1:0] steps [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k == 0, 4'd1, steps[k], 1'b1);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL game_over step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
        total++;
        if ({gameover_b, who_b, count_b} !== {1'b1, 2'b01, 4'd0}) begin
            bad++;
            $display("[TB] FAIL game_over_b_frozen: got %b want %b",
                     {gameover_b, who_b, count_b}, {1'b1, 2'b01, 4'd0});
        end
    endtask

    // Enable low holds count, restart from OVER, held INIT on 0 and MAX
    task automatic test_enable_restart();
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:          applyStimulus(1'b0, 4'd0, 2'b01, 1'b0);
                1, 2, 3:    applyStimulus(1'b0, 4'd0, 2'(k), 1'b0);
                4:          applyStimulus(1'b1, 4'd5, 2'b00, 1'b1);
                5:          applyStimulus(1'b0, 4'd0, 2'b00, 1'b1);
                6, 7:       applyStimulus(1'b1, 4'd0, 2'b10, 1'b1);
                8:          applyStimulus(1'b0, 4'd0, 2'b11, 1'b1);
                9:          applyStimulus(1'b1, 4'd15, 2'b00, 1'b1);
                10:         applyStimulus(1'b0, 4'd0, 2'b10, 1'b0);
                default:    applyStimulus(1'b0, 4'd0, 2'b10, 1'b1);
            endcase
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL enable_restart step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
    endtask

    // Consecutive qualifying steps give consecutive pulses
    task automatic test_back_to_back();
        logic [1:0] steps [6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k == 0, 4'd14, steps[k], 1'b1);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL back_to_back step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
    endtask

    // Random mix of steps, enables and occasional restarts
    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            applyStimulus(($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            total++;
            if (obs_now !== exp_v) begin
                bad++;
                $display("[TB] FAIL random step%0d: got %h want %h", k, obs_now, exp_v);
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
    endtask

    // Test sequence
    initial begin
        total      = 0;
        bad        = 0;
        rst_l      = 1'b0;
        init       = 1'b0;
        load_value = 4'd0;
        ctrl       = 2'b00;
        en         = 1'b0;
        ma         = '0;
        mb         = '0;
        test_reset();
        test_wrap();
        test_game_over();
        test_enable_restart();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
